s1_digit_ctrl: RTL and testbench

- Tens-of-seconds digit (S1) of the stopwatch: the receiving end of the S0 digit's carry/borrow pulse.
- Counts 0..MAX_DIGIT up or down and forwards carry/borrow to the minutes chain.
- Returns the freeze signal (term_out) and clear signal (comp_out) that S0 consumes.
- Holds the terminal conditions in an explicit FSM, so the watch freezes cleanly on up-mode overflow and on down-mode expiry.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/s1_digit_ctrl_if.sv | 31 +++
 rtl/s1_digit_ctrl_digit_updown_reg.sv | 47 ++++
 rtl/s1_digit_ctrl.sv | 109 ++++++++++
 tb/tb_s1_digit_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants.
//   s1_state_t   : S1 terminal-condition FSM states (2-bit encoding)
//   SEC_TENS_MAX : highest value of the tens-of-seconds digit
//   DIGIT_W      : width of a single BCD-style digit register
package stopwatch_pkg;

  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_W      = 4;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    OVF_HOLD = 2'd1,
    EXPIRED  = 2'd2
  } s1_state_t;

endpackage

// File: rtl/s1_digit_ctrl_if.sv
// Bus between the S1 digit controller and its neighbours in the digit chain.
//   master : drives start/ups/carry_in/upper_term_in/upper_comp_in,
//            observes out_S1/carry_out/term_out/comp_out/expired/overflow
//   slave  : the S1 controller itself (mirror of master)
interface s1_digit_ctrl_if
  import stopwatch_pkg::*;
#(
  parameter int WIDTH = DIGIT_W
);
  logic             start;
  logic             ups;
  logic             carry_in;
  logic             upper_term_in;
  logic             upper_comp_in;
  logic [WIDTH-1:0] out_S1;
  logic             carry_out;
  logic             term_out;
  logic             comp_out;
  logic             expired;
  logic             overflow;

  modport master (
    output start, ups, carry_in, upper_term_in, upper_comp_in,
    input  out_S1, carry_out, term_out, comp_out, expired, overflow
  );

  modport slave (
    input  start, ups, carry_in, upper_term_in, upper_comp_in,
    output out_S1, carry_out, term_out, comp_out, expired, overflow
  );
endinterface

// File: rtl/s1_digit_ctrl_digit_updown_reg.sv
// Reusable up/down digit register with wrap (up) and reload (down).
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (digit -> 0)
//   i_clr   : synchronous clear, beats i_en
//   i_en    : apply one count step this cycle
//   i_up    : 1 = count up, 0 = count down
//   o_q     : current digit value
//   o_wrap  : a step taken now would wrap to 0 (up) or reload MAX (down);
//             values above MAX are treated as wrapping in both directions
module digit_updown_reg #(
  parameter int WIDTH = 4,
  parameter int MAX   = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_up,
  output logic [WIDTH-1:0] o_q,
  output logic             o_wrap
);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] r_q;

  assign o_wrap = i_up ? (r_q >= MAX_V) : ((r_q == ZERO_V) || (r_q > MAX_V));
  assign o_q    = r_q;

  // Digit register: clear, then wrap/reload or step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= ZERO_V;
    end else if (i_clr) begin
      r_q <= ZERO_V;
    end else if (i_en) begin
      if (o_wrap) begin
        r_q <= i_up ? ZERO_V : MAX_V;
      end else begin
        r_q <= i_up ? (r_q + ONE_V) : (r_q - ONE_V);
      end
    end else begin
      r_q <= r_q;
    end
  end
endmodule

// File: rtl/s1_digit_ctrl.sv
// Tens-of-seconds (S1) stopwatch digit controller.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of s1_digit_ctrl_if (run/mode/carry/term/clear in,
//           digit, carry_out, term_out, comp_out, expired, overflow out)
// Counts on the S0 carry/borrow pulse, forwards carry/borrow upward and
// freezes the watch on up-mode overflow or down-mode expiry.
module s1_digit_ctrl
  import stopwatch_pkg::*;
#(
  parameter int WIDTH     = DIGIT_W,
  parameter int MAX_DIGIT = SEC_TENS_MAX
) (
  input  logic           clk,
  input  logic           reset,
  s1_digit_ctrl_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_DIGIT);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

  s1_state_t        r_state;
  logic             r_expired;
  logic             r_overflow;
  logic             r_ups_q;
  logic [WIDTH-1:0] w_digit;
  logic             w_wrap;
  logic             w_en;
  logic             w_step;
  logic             w_ovf_trig;
  logic             w_exp_trig;
  logic             w_mode_chg;
  logic             w_frozen;

  assign w_frozen   = (r_state != RUN);
  assign w_en       = bus.start & ~w_frozen;
  assign w_mode_chg = (bus.ups != r_ups_q);
  assign w_ovf_trig = w_en & bus.ups & bus.carry_in & (w_digit == MAX_V) & bus.upper_term_in;
  assign w_exp_trig = w_en & ~bus.ups & (w_digit == ZERO_V) & bus.upper_term_in;
  // Once expiry is reached the digit must stay at 0, so a stray borrow in
  // the same cycle is swallowed instead of reloading MAX.
  assign w_step     = w_en & bus.carry_in & ~bus.upper_comp_in & ~w_exp_trig;

  digit_updown_reg #(
    .WIDTH (WIDTH),
    .MAX   (MAX_DIGIT)
  ) u_digit (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clr   (bus.upper_comp_in),
    .i_en    (w_step),
    .i_up    (bus.ups),
    .o_q     (w_digit),
    .o_wrap  (w_wrap)
  );

  // Terminal FSM, sticky flags and previous-mode register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_expired  <= 1'b0;
      r_overflow <= 1'b0;
      r_ups_q    <= 1'b0;
    end else begin
      r_ups_q <= bus.ups;
      if (bus.upper_comp_in) begin
        r_state    <= RUN;
        r_expired  <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        case (r_state)
          RUN: begin
            if (w_ovf_trig) begin
              r_state    <= OVF_HOLD;
              r_overflow <= 1'b1;
            end else if (w_exp_trig) begin
              r_state   <= EXPIRED;
              r_expired <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
          OVF_HOLD, EXPIRED: begin
            // Flipping the mode is how the user leaves a frozen watch.
            if (w_mode_chg) begin
              r_state    <= RUN;
              r_expired  <= 1'b0;
              r_overflow <= 1'b0;
            end else begin
              r_state <= r_state;
            end
          end
          default: begin
            r_state    <= RUN;
            r_expired  <= 1'b0;
            r_overflow <= 1'b0;
          end
        endcase
      end
    end
  end

  // Combinational chain outputs are forced low while reset is held.
  assign bus.carry_out = reset & w_step & w_wrap;
  assign bus.term_out  = reset & (w_frozen | (~bus.ups & (w_digit == ZERO_V) & bus.upper_term_in));
  assign bus.comp_out  = reset & (bus.upper_comp_in | (w_frozen & w_mode_chg));
  assign bus.out_S1    = w_digit;
  assign bus.expired   = r_expired;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_s1_digit_ctrl.sv
module tb_s1_digit_ctrl;
  localparam int MAX = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  // reference model: digit as an integer, flags as the frozen condition
  int   m_d = 0;
  bit   m_ovf = 1'b0;
  bit   m_exp = 1'b0;
  bit   m_pups = 1'b0;

  s1_digit_ctrl_if #(.WIDTH(4)) bif ();

  s1_digit_ctrl #(.WIDTH(4), .MAX_DIGIT(MAX)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit st, input bit up, input bit ci, input bit ut, input bit cp);
    bif.start = st; bif.ups = up; bif.carry_in = ci;
    bif.upper_term_in = ut; bif.upper_comp_in = cp;
  endtask

  // one clock: check combinational outputs, clock, advance model, check registers
  task automatic cycle(input bit st, input bit up, input bit ci, input bit ut, input bit cp);
    bit frozen, en, et, stp, e_carry, e_term, e_comp;
    drive(st, up, ci, ut, cp);
    #1;
    frozen  = m_ovf | m_exp;
    en      = st & ~frozen;
    et      = en & ~up & (m_d == 0) & ut;
    stp     = en & ci & ~cp & ~et;
    e_carry = stp & (up ? (m_d == MAX) : (m_d == 0));
    e_term  = frozen | (~up & (m_d == 0) & ut);
    e_comp  = cp | (frozen & (up != m_pups));
    chk("carry_out", 32'(bif.carry_out), 32'(e_carry));
    chk("term_out",  32'(bif.term_out),  32'(e_term));
    chk("comp_out",  32'(bif.comp_out),  32'(e_comp));
    @(posedge clk);
    if (cp) begin
      m_d = 0; m_ovf = 1'b0; m_exp = 1'b0;
    end else begin
      if (en & up & ci & (m_d == MAX) & ut) m_ovf = 1'b1;
      else if (et) m_exp = 1'b1;
      if (stp) m_d = up ? (m_d + 1) % (MAX + 1) : (m_d + MAX) % (MAX + 1);
      if (frozen && (up != m_pups)) begin
        m_ovf = 1'b0; m_exp = 1'b0;
      end
    end
    m_pups = up;
    #1;
    chk("out_S1",   32'(bif.out_S1),   m_d);
    chk("expired",  32'(bif.expired),  32'(m_exp));
    chk("overflow", 32'(bif.overflow), 32'(m_ovf));
  endtask

  task automatic release_reset(input bit up);
    drive(1'b0, up, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_pups = up;
    #1;
  endtask

  // reset asserted mid-cycle with inputs still active; all must clear at once
  task automatic async_reset(input string tag, input bit up);
    #3;
    rst_n = 1'b0;
    #1;
    chk({tag, "_digit"},    32'(bif.out_S1),    32'd0);
    chk({tag, "_expired"},  32'(bif.expired),   32'd0);
    chk({tag, "_overflow"}, 32'(bif.overflow),  32'd0);
    chk({tag, "_carry"},    32'(bif.carry_out), 32'd0);
    chk({tag, "_term"},     32'(bif.term_out),  32'd0);
    chk({tag, "_comp"},     32'(bif.comp_out),  32'd0);
    m_d = 0; m_ovf = 1'b0; m_exp = 1'b0;
    release_reset(up);
  endtask

  initial begin
    bit st, up, ci, ut, cp;

    // reset state with every input asserted
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    #3;
    chk("rst_digit",    32'(bif.out_S1),    32'd0);
    chk("rst_expired",  32'(bif.expired),   32'd0);
    chk("rst_overflow", 32'(bif.overflow),  32'd0);
    chk("rst_carry",    32'(bif.carry_out), 32'd0);
    chk("rst_term",     32'(bif.term_out),  32'd0);
    chk("rst_comp",     32'(bif.comp_out),  32'd0);
    release_reset(1'b1);

    // up count: 12 pulses, 10 cycles apart
    for (int p = 1; p <= 12; p++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("up_seq", 32'(bif.out_S1), p % 6);
      for (int k = 0; k < 9; k++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end

    // start low holds the digit
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_start_low", 32'(bif.out_S1), 32'd1);

    // down count from 0: reload 5 with borrow, then 4
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("down_reload", 32'(bif.out_S1), 32'd5);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("down_step", 32'(bif.out_S1), 32'd4);

    // expiry at 0 with upper digits at zero
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("exp_flag", 32'(bif.expired), 32'd1);
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("exp_frozen", 32'(bif.out_S1), 32'd0);
    async_reset("rst_in_expired", 1'b1);

    // count to 4, then async reset mid-cycle and resume from 0
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_4", 32'(bif.out_S1), 32'd4);
    async_reset("rst_at_4", 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("resume", 32'(bif.out_S1), 32'd1);

    // overflow: 1 -> 5, then carry at 5 with upper digits full
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("ovf_flag", 32'(bif.overflow), 32'd1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovf_frozen", 32'(bif.out_S1), 32'd0);

    // mode toggle leaves OVF_HOLD with a one-cycle comp_out
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mode_exit", 32'(bif.overflow), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // clear beats a simultaneous carry at digit 3
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pre_clear_3", 32'(bif.out_S1), 32'd3);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("clear_wins", 32'(bif.out_S1), 32'd0);

    // randomized traffic against the model
    up = 1'b1;
    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(7) != 0);
      if ($urandom_range(15) == 0) up = ~up;
      ci = ($urandom_range(2) == 0);
      ut = ($urandom_range(5) == 0);
      cp = ($urandom_range(31) == 0);
      if (ut && !up) ci = 1'b0;
      cycle(st, up, ci, ut, cp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
